// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard of in-flight register writers
// with per-entry Tnew countdowns. It produces the D-stage stall and the D/E
// forwarding selects, and it applies a mult/div busy interlock.
// Optional macro HAZ_PERF_CNT_EN adds two 32-bit stall-cause counters.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int RAW      = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SW       = $clog2(NSTAGE + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [RAW-1:0] rs_d,
  input  logic [RAW-1:0] rt_d,
  input  logic           use_rs_d,
  input  logic           use_rt_d,
  input  logic [TW-1:0]  tuse_rs_d,
  input  logic [TW-1:0]  tuse_rt_d,
  input  logic           wr_d,
  input  logic [RAW-1:0] a3_d,
  input  logic [TW-1:0]  tnew_d,
  input  logic           md_use_d,
  input  logic           md_start_e,
  input  logic           md_div_e,
  output logic           stall,
  output logic [SW-1:0]  fwd_rs_d,
  output logic [SW-1:0]  fwd_rt_d,
  output logic [SW-1:0]  fwd_rs_e,
  output logic [SW-1:0]  fwd_rt_e,
  output logic           md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]    stall_raw_cnt,
  output logic [31:0]    stall_md_cnt
`endif
);

  localparam int MDMAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW    = $clog2(MDMAX + 1);
  localparam int LW    = SW + TW + 1;  // {hit, select, tnew}

  logic [NSTAGE-1:0]          valid_r;
  logic [NSTAGE-1:0][RAW-1:0] a3_r;
  logic [NSTAGE-1:0][RAW-1:0] rs_r;
  logic [NSTAGE-1:0][RAW-1:0] rt_r;
  logic [NSTAGE-1:0][TW-1:0]  tnew_r;
  logic [CW-1:0]              md_cnt_r;

  logic [LW-1:0] d_rs_s, d_rt_s, e_rs_s, e_rt_s;
  logic          haz_rs_s, haz_rt_s, raw_haz_s, md_busy_s, stall_s;

  // Youngest (lowest-index) valid writer of x at or above entry lo.
  // Scanning oldest-first lets younger matches overwrite older ones.
  function automatic logic [LW-1:0] find_writer(
    input logic [RAW-1:0]             x,
    input logic [NSTAGE-1:0]          v,
    input logic [NSTAGE-1:0][RAW-1:0] a3,
    input logic [NSTAGE-1:0][TW-1:0]  tn,
    input int                         lo
  );
    logic          hit;
    logic [SW-1:0] sel;
    logic [TW-1:0] t;
    hit = 1'b0;
    sel = '0;
    t   = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (i >= lo && v[i] && a3[i] == x && x != '0) begin
        hit = 1'b1;
        sel = SW'(i + 1);
        t   = tn[i];
      end else begin
        hit = hit;
      end
    end
    return {hit, sel, t};
  endfunction

  // A match can forward only once its result is on a bus (tnew reached 0).
  function automatic logic [SW-1:0] pick_fwd(input logic [LW-1:0] r, input logic en);
    if (en && r[LW-1] && r[TW-1:0] == '0) begin
      return r[LW-2:TW];
    end else begin
      return '0;
    end
  endfunction

  // The operand is late when the writer needs longer than the reader can wait.
  function automatic logic is_late(input logic [LW-1:0] r, input logic en,
                                   input logic [TW-1:0] tuse);
    return en && r[LW-1] && (r[TW-1:0] > tuse);
  endfunction

  // Operand lookups: D operands over all entries, E operands over entries 1..
  always_comb begin
    d_rs_s = find_writer(rs_d, valid_r, a3_r, tnew_r, 0);
    d_rt_s = find_writer(rt_d, valid_r, a3_r, tnew_r, 0);
    e_rs_s = find_writer(rs_r[0], valid_r, a3_r, tnew_r, 1);
    e_rt_s = find_writer(rt_r[0], valid_r, a3_r, tnew_r, 1);
  end

  // Hazard, stall, busy and forward-select decode; reset forces quiet outputs.
  always_comb begin
    haz_rs_s  = is_late(d_rs_s, use_rs_d, tuse_rs_d);
    haz_rt_s  = is_late(d_rt_s, use_rt_d, tuse_rt_d);
    raw_haz_s = rst_n && (haz_rs_s || haz_rt_s);
    md_busy_s = rst_n && (md_start_e || md_cnt_r != '0);
    stall_s   = raw_haz_s || (md_use_d && md_busy_s);
    stall     = stall_s;
    md_busy   = md_busy_s;
    fwd_rs_d  = pick_fwd(d_rs_s, use_rs_d);
    fwd_rt_d  = pick_fwd(d_rt_s, use_rt_d);
    fwd_rs_e  = pick_fwd(e_rs_s, 1'b1);
    fwd_rt_e  = pick_fwd(e_rt_s, 1'b1);
  end

  // Scoreboard shift: D enters entry 0 (bubble on stall), older entries age.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      a3_r    <= '0;
      rs_r    <= '0;
      rt_r    <= '0;
      tnew_r  <= '0;
    end else begin
      if (stall_s) begin
        valid_r[0] <= 1'b0;
        a3_r[0]    <= '0;
        tnew_r[0]  <= '0;
        rs_r[0]    <= '0;
        rt_r[0]    <= '0;
      end else begin
        valid_r[0] <= wr_d && (a3_d != '0);
        a3_r[0]    <= a3_d;
        tnew_r[0]  <= tnew_d;
        rs_r[0]    <= rs_d;
        rt_r[0]    <= rt_d;
      end
      for (int k = 0; k < NSTAGE - 1; k++) begin
        valid_r[k+1] <= valid_r[k];
        a3_r[k+1]    <= a3_r[k];
        rs_r[k+1]    <= rs_r[k];
        rt_r[k+1]    <= rt_r[k];
        tnew_r[k+1]  <= (tnew_r[k] != '0) ? tnew_r[k] - TW'(1) : '0;
      end
    end
  end

  // Mult/div occupancy counter; a new start always reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_r <= '0;
    end else if (md_start_e) begin
      md_cnt_r <= md_div_e ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt_r != '0) begin
      md_cnt_r <= md_cnt_r - CW'(1);
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Stall-cause counters; a register hazard takes precedence so no cycle counts twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_raw_cnt <= 32'd0;
      stall_md_cnt  <= 32'd0;
    end else if (raw_haz_s) begin
      stall_raw_cnt <= stall_raw_cnt + 32'd1;
    end else if (md_use_d && md_busy_s) begin
      stall_md_cnt  <= stall_md_cnt + 32'd1;
    end else begin
      stall_raw_cnt <= stall_raw_cnt;
      stall_md_cnt  <= stall_md_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard. The driver pushes the expected
// outputs of each cycle into a queue; a monitor pops and compares on the
// falling edge. A value of -1 in an expectation means "don't care".
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, a3_d;
  logic       use_rs_d, use_rt_d, wr_d, md_use_d, md_start_e, md_div_e;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_raw_cnt, stall_md_cnt;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .wr_d(wr_d), .a3_d(a3_d), .tnew_d(tnew_d),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .md_div_e(md_div_e),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
`ifdef HAZ_PERF_CNT_EN
    , .stall_raw_cnt(stall_raw_cnt), .stall_md_cnt(stall_md_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    s, b, rsd, rtd, rse, rte;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic cmp(input string nm, input int got, input int want);
    if (want >= 0) begin
      n_chk++;
      if (got != want) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", nm, got, want);
      end
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp({mon_e.nm, "/stall"},    int'(stall),    mon_e.s);
      cmp({mon_e.nm, "/md_busy"},  int'(md_busy),  mon_e.b);
      cmp({mon_e.nm, "/fwd_rs_d"}, int'(fwd_rs_d), mon_e.rsd);
      cmp({mon_e.nm, "/fwd_rt_d"}, int'(fwd_rt_d), mon_e.rtd);
      cmp({mon_e.nm, "/fwd_rs_e"}, int'(fwd_rs_e), mon_e.rse);
      cmp({mon_e.nm, "/fwd_rt_e"}, int'(fwd_rt_e), mon_e.rte);
    end
  end

  task automatic push(input string nm, input int s, input int b,
                      input int rsd, input int rtd, input int rse, input int rte);
    exp_t e;
    e.nm = nm; e.s = s; e.b = b; e.rsd = rsd; e.rtd = rtd; e.rse = rse; e.rte = rte;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_d = 5'd0; rt_d = 5'd0; a3_d = 5'd0;
    use_rs_d = 1'b0; use_rt_d = 1'b0; wr_d = 1'b0;
    tuse_rs_d = 2'd0; tuse_rt_d = 2'd0; tnew_d = 2'd0;
    md_use_d = 1'b0; md_start_e = 1'b0; md_div_e = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); idle();
      push("drain", -1, -1, -1, -1, -1, -1);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    // In reset: requests must not leak to the outputs.
    tick(); idle();
    md_start_e = 1'b1; md_use_d = 1'b1; use_rs_d = 1'b1; rs_d = 5'd3;
    push("in_reset", 0, 0, 0, 0, 0, 0);
    tick(); idle(); rst_n = 1'b1;
    push("post_reset", 0, 0, 0, 0, 0, 0);
    drain(2);

    // Load-use: tnew 2 writer, tuse 0 reader -> two stall cycles, then W forward.
    tick(); idle(); wr_d = 1'b1; a3_d = 5'd8; tnew_d = 2'd2;
    push("lu_c0", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(); idle(); use_rs_d = 1'b1; rs_d = 5'd8;
      push($sformatf("lu_c%0d", i), (i < 3) ? 1 : 0, 0, (i < 3) ? 0 : 3, 0, 0, 0);
    end
    tick(); idle();
    push("lu_c4", 0, 0, 0, 0, 0, 0);
    drain(4);

    // ALU forward: writer tnew 1, reader tuse 1 -> no stall, E takes M (entry 1 => select 2).
    tick(); idle(); wr_d = 1'b1; a3_d = 5'd9; tnew_d = 2'd1;
    push("alu_c0", 0, 0, 0, 0, 0, 0);
    tick(); idle(); use_rt_d = 1'b1; rt_d = 5'd9; tuse_rt_d = 2'd1;
    push("alu_c1", 0, 0, 0, 0, 0, 0);
    tick(); idle();
    push("alu_c2", 0, 0, 0, 0, 0, 2);
    drain(4);

    // Shadowing: two writers of $5; the younger one (tnew 1) wins.
    tick(); idle(); wr_d = 1'b1; a3_d = 5'd5; tnew_d = 2'd0;
    push("sh_c0", 0, 0, 0, 0, 0, 0);
    tick(); idle(); wr_d = 1'b1; a3_d = 5'd5; tnew_d = 2'd1;
    push("sh_c1", 0, 0, 0, 0, 0, 0);
    tick(); idle(); use_rs_d = 1'b1; rs_d = 5'd5; tuse_rs_d = 2'd1;
    push("sh_c2", 0, 0, 0, 0, 0, 0);
    tick(); idle();
    push("sh_c3", 0, 0, 0, 0, 2, 0);
    drain(4);

    // $0 never hazards; an unused operand never hazards; a used one does.
    tick(); idle(); wr_d = 1'b1; a3_d = 5'd0; tnew_d = 2'd0;
    push("z_c0", 0, 0, 0, 0, 0, 0);
    tick(); idle(); use_rs_d = 1'b1; rs_d = 5'd0;
    push("z_c1", 0, 0, 0, 0, 0, 0);
    tick(); idle(); wr_d = 1'b1; a3_d = 5'd7; tnew_d = 2'd3;
    push("z_c2", 0, 0, 0, 0, 0, 0);
    tick(); idle(); rs_d = 5'd7;
    push("unused_c3", 0, 0, 0, 0, 0, 0);
    tick(); idle(); use_rs_d = 1'b1; rs_d = 5'd7;
    push("used_c4", 1, 0, 0, 0, 0, 0);
    drain(4);

    // Div: busy in the start cycle, then exactly 10 more cycles.
    tick(); idle(); md_start_e = 1'b1; md_div_e = 1'b1; md_use_d = 1'b1;
    push("div_start", 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick(); idle(); md_use_d = 1'b1;
      push($sformatf("div_busy%0d", i), 1, 1, 0, 0, 0, 0);
    end
    tick(); idle(); md_use_d = 1'b1;
    push("div_done", 0, 0, 0, 0, 0, 0);
    drain(1);

    // Mult: 5 busy cycles after start.
    tick(); idle(); md_start_e = 1'b1; md_use_d = 1'b1;
    push("mul_start", 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(); idle(); md_use_d = 1'b1;
      push($sformatf("mul_busy%0d", i), 1, 1, 0, 0, 0, 0);
    end
    tick(); idle(); md_use_d = 1'b1;
    push("mul_done", 0, 0, 0, 0, 0, 0);
    drain(1);

    // Reload: mult issued while a div is running supersedes it.
    tick(); idle(); md_start_e = 1'b1; md_div_e = 1'b1;
    push("rl_div", 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      tick(); idle();
      push($sformatf("rl_busy%0d", i), 0, 1, 0, 0, 0, 0);
    end
    tick(); idle(); md_start_e = 1'b1;
    push("rl_mul", 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(); idle();
      push($sformatf("rl_mbusy%0d", i), 0, 1, 0, 0, 0, 0);
    end
    tick(); idle();
    push("rl_done", 0, 0, 0, 0, 0, 0);
    drain(1);

    // Reset mid-div with a writer in flight; outputs drop without a clock edge.
    tick(); idle(); wr_d = 1'b1; a3_d = 5'd12; tnew_d = 2'd3;
    md_start_e = 1'b1; md_div_e = 1'b1;
    push("rb_start", 0, 1, 0, 0, 0, 0);
    tick(); idle(); md_use_d = 1'b1;
    push("rb_busy", 1, 1, 0, 0, 0, 0);
    tick(); idle(); md_use_d = 1'b1; rst_n = 1'b0;
    push("rb_async", 0, 0, 0, 0, 0, 0);
    tick(); idle(); md_use_d = 1'b1;
    push("rb_held", 0, 0, 0, 0, 0, 0);
    tick(); idle(); rst_n = 1'b1; md_use_d = 1'b1; use_rs_d = 1'b1; rs_d = 5'd12;
    push("rb_release", 0, 0, 0, 0, 0, 0);
    tick(); idle();
    push("rb_after", 0, 0, 0, 0, 0, 0);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
